fifo_flush_unpack_reader: RTL
=============================

# fifo_flush_unpack_reader

Read-side drain engine for the flushable nibble FIFO. It pulls 32-bit words from the FIFO read port, serialises each word into eight 4-bit nibbles (LSB nibble first) on a valid/ready stream, and propagates a flush request back into the FIFO. It is the consumer counterpart of the 4-bit write path and sits entirely in the read clock domain, between the FIFO and the nibble sink.

## Interface
- DATA_W, 32: FIFO read word width.
- NIB_W, 4: output nibble width.
- NIBBLES, DATA_W/NIB_W = 8: nibbles per word (derived, not overridable).

- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge of `clock`.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_rd_data_i  in  DATA_W  FIFO read data, valid the cycle after `fifo_rd_valid_o`.
- fifo_rd_valid_o  out  1  one-cycle FIFO read strobe.
- fifo_flush_o  out  1  one-cycle flush request to the FIFO.
- flush_i  in  1  flush command from the controller.
- nib_data_o  out  NIB_W  current nibble.
- nib_valid_o  out  1  nibble valid.
- nib_ready_i  in  1  sink ready; a transfer occurs when valid & ready.
- nib_last_o  out  1  current nibble is the last nibble of its word.
- nib_idx_o  out  3  index of the current nibble within its word (0..7).
- busy_o  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, REQ, CAPT, SEND, FLUSH.
- IDLE: if `fifo_empty_i`=0 and `flush_i`=0, go to REQ.
- REQ: `fifo_rd_valid_o`=1 for this cycle only; go to CAPT.
- CAPT: load `fifo_rd_data_i` into the shift register, set idx=0, go to SEND.
- SEND: `nib_data_o` = shreg[3:0].
  - On a transfer: shift shreg right by NIB_W and increment idx.
  - On a transfer with idx=7: go to REQ if `fifo_empty_i`=0, otherwise go to IDLE.
- FLUSH: `fifo_flush_o`=1; clear shreg and idx; go to IDLE.
- `flush_i`=1 in any state moves the FSM to FLUSH on the next edge. It has priority over every other transition.
  - A word strobed in REQ, or sitting in CAPT, is discarded.
  - Nibbles not yet transferred from the current word are discarded.
  - `flush_i` held high keeps the FSM in FLUSH, with `fifo_flush_o` high every cycle.
- Output decode:
  - `nib_valid_o` = (state==SEND) & ~`flush_i`. This is the only combinational input-to-output path, and it guarantees no transfer happens in a flush cycle.
  - `nib_last_o` = `nib_valid_o` & (idx==7).
  - `nib_idx_o` = idx.
- Handshake: while `nib_valid_o`=1 and `nib_ready_i`=0, `nib_data_o`, `nib_idx_o` and `nib_last_o` hold stable. The sink must not assume `nib_valid_o` stays high across a flush.
- Width rules:
  - idx is 3 bits; it wraps only through the idx=7 exit.
  - The shift register fills its MSBs with zeros.

## Timing
- Reset values: every output 0, state IDLE, shreg 0, idx 0.
- `reset` asserted mid-word drops the word; it does not generate `fifo_flush_o`.
- Start-up latency, with `fifo_empty_i` falling and sampled at edge 0:
  - `fifo_rd_valid_o` high in cycle 1.
  - Capture in cycle 2.
  - First `nib_valid_o` in cycle 3.
- Throughput with `nib_ready_i`=1: 8 nibble cycles plus 2 overhead cycles (REQ, CAPT) per word. Back-to-back words see 2 invalid cycles between the last nibble of one word and the first nibble of the next.
- Flush latency: `flush_i` sampled at edge t → `fifo_flush_o` high in cycle t+1 → IDLE in cycle t+2. The earliest new REQ is cycle t+3.
- Empty boundary: the empty flag is sampled only in IDLE and at the idx=7 transfer. The FSM never strobes a read while `fifo_empty_i`=1.

## Structure
- Shared package `fifo_flush_pkg` holds:
  - DATA_W, NIB_W and NIBBLES constants;
  - the state enum type for IDLE/REQ/CAPT/SEND/FLUSH;
  - the nibble index type.
- The write-side blocks reuse the same package.
- One sub-module is natural: `fifo_unpack_shreg`. It covers load, shift and clear of the DATA_W shift register and exposes the low nibble.
- The FSM, idx counter and output decode stay in the top module.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with `fifo_empty_i`=0 → all outputs 0; after release, `fifo_rd_valid_o` rises in the first cycle.
- Single word: FIFO returns 0x87654321, `nib_ready_i`=1 → nibbles 1,2,3,4,5,6,7,8 in cycles 3–10, `nib_last_o` only in cycle 10, then IDLE with `busy_o`=0.
- Backpressure: word 0xA35D0B14 with `nib_ready_i` toggling every cycle, starting low → each nibble held for 2 cycles with data stable, 8 transfers in order 4,1,B,0,D,5,3,A, then IDLE.
- Mid-word flush: `flush_i` pulsed for 1 cycle after 3 transfers of 0x87654321 → `nib_valid_o`=0 in that cycle, `fifo_flush_o` high for exactly 1 cycle, nibbles 4–8 never appear, `nib_idx_o` returns to 0.
- Flush during REQ: `flush_i` asserted in the REQ cycle → no `nib_valid_o` for that word; `fifo_flush_o` pulses in the following cycle.
- Back-to-back: two words 0x11111111 and 0x22222222 with `fifo_empty_i`=0 → second `fifo_rd_valid_o` in the cycle after the 8th transfer, exactly 2 invalid cycles between the words, 16 transfers in total.

Source files
------------

// File: rtl/fifo_flush_pkg.sv
// Shared constants and types for the flushable nibble FIFO read and write paths.
// Combinational only: no latency and no backpressure of its own.
package fifo_flush_pkg;

  localparam int DATA_W  = 32;
  localparam int NIB_W   = 4;
  localparam int NIBBLES = DATA_W / NIB_W;
  localparam int IDX_W   = $clog2(NIBBLES);

  typedef logic [IDX_W-1:0] nib_idx_t;

  localparam nib_idx_t IDX_LAST = nib_idx_t'(NIBBLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_CAPT,
    ST_SEND,
    ST_FLUSH
  } rd_state_e;

endpackage

// File: rtl/fifo_unpack_shreg.sv
// Word-to-nibble shift register: load, zero-filling right shift, clear; low nibble exposed.
// Updates on the edge after a control is seen; it holds while no control is active (backpressure).
module fifo_unpack_shreg
  import fifo_flush_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] load_data,
  output logic [NIB_W-1:0]  nib
);

  logic [DATA_W-1:0] shreg;

  // Clear beats load so a word captured in a flush cycle never reaches the sink.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= load_data;
    end else if (shift) begin
      shreg <= {{NIB_W{1'b0}}, shreg[DATA_W-1:NIB_W]};
    end
  end

  assign nib = shreg[NIB_W-1:0];

endmodule

// File: rtl/fifo_flush_unpack_reader.sv
// FIFO drain engine: reads 32-bit words and emits 8 nibbles LSB first; first nibble 3 cycles after non-empty.
// Nibbles hold while nib_ready_i is low; flush_i overrides everything and is echoed as fifo_flush_o.
module fifo_flush_unpack_reader
  import fifo_flush_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_rd_data_i,
  output logic              fifo_rd_valid_o,
  output logic              fifo_flush_o,
  input  logic              flush_i,
  output logic [NIB_W-1:0]  nib_data_o,
  output logic              nib_valid_o,
  input  logic              nib_ready_i,
  output logic              nib_last_o,
  output logic [2:0]        nib_idx_o,
  output logic              busy_o
);

  rd_state_e state;
  rd_state_e state_nxt;
  nib_idx_t  idx;
  logic      xfer;
  logic      clr;

  // Gating valid with flush_i keeps any nibble from being accepted in a flush cycle.
  assign nib_valid_o = (state == ST_SEND) && !flush_i;
  assign xfer        = nib_valid_o && nib_ready_i;
  assign nib_last_o  = nib_valid_o && (idx == IDX_LAST);
  assign nib_idx_o   = idx;
  assign clr         = flush_i || (state == ST_FLUSH);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!fifo_empty_i) state_nxt = ST_REQ;
      ST_REQ:   state_nxt = ST_CAPT;
      ST_CAPT:  state_nxt = ST_SEND;
      ST_SEND:  if (xfer && (idx == IDX_LAST)) state_nxt = fifo_empty_i ? ST_IDLE : ST_REQ;
      ST_FLUSH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (flush_i) state_nxt = ST_FLUSH;
  end

  // Strobe, flush and busy are registered from the next state so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_IDLE;
      idx             <= '0;
      fifo_rd_valid_o <= 1'b0;
      fifo_flush_o    <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      state           <= state_nxt;
      fifo_rd_valid_o <= (state_nxt == ST_REQ);
      fifo_flush_o    <= (state_nxt == ST_FLUSH);
      busy_o          <= (state_nxt != ST_IDLE);
      if (clr || (state == ST_CAPT)) begin
        idx <= '0;
      end else if (xfer) begin
        idx <= idx + 1'b1;
      end
    end
  end

  fifo_unpack_shreg u_shreg (
    .clock     (clock),
    .reset     (reset),
    .clear     (clr),
    .load      (state == ST_CAPT),
    .shift     (xfer),
    .load_data (fifo_rd_data_i),
    .nib       (nib_data_o)
  );

endmodule
